// File: rtl/mem_seq_if.sv
// Request/strobe bundle between the control unit and the memory-access sequencer.
interface mem_seq_if;
    logic       if_req;
    logic       ld_req;
    logic       st_req;
    logic       PCout;
    logic       ADDRout;
    logic       DATAout;
    logic       MARin;
    logic       MDRin;
    logic       read;
    logic       mem_rd;
    logic       mem_wr;
    logic [1:0] gnt;
    logic       busy;
    logic       if_done;
    logic       ld_done;
    logic       st_done;

    // Control-unit side: raises requests, watches strobes and done pulses.
    modport master (
        output if_req, ld_req, st_req,
        input  PCout, ADDRout, DATAout, MARin, MDRin, read, mem_rd, mem_wr,
        input  gnt, busy, if_done, ld_done, st_done
    );

    // Sequencer side.
    modport slave (
        input  if_req, ld_req, st_req,
        output PCout, ADDRout, DATAout, MARin, MDRin, read, mem_rd, mem_wr,
        output gnt, busy, if_done, ld_done, st_done
    );
endinterface

// File: rtl/mem_seq.sv
// Memory-access sequencer: arbitrates fetch/load/store over the shared
// MAR/MDR/memory path and issues the per-cycle control strobes.
//
// state | meaning
// IDLE  | no owner; arbitrate pending requests
// ADDR  | address (PC or EA) onto bus, load MAR
// SD0   | store data onto bus, MDR input select = bus
// SD1   | load MDR from its input stage
// WAIT  | hold mem_rd / mem_wr for MEM_LAT cycles
// CAP   | MDR input stage captures memory data
// LAT   | load MDR from captured memory data
// DONE  | done pulse to the owner
module mem_seq #(
    parameter int MEM_LAT = 2
) (
    input  logic      clk,
    input  logic      clear,
    mem_seq_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_SD0, S_SD1, S_WAIT, S_CAP, S_LAT, S_DONE
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_last_data;
    logic [1:0] r_gnt;
    logic       r_busy;
    logic       r_pc_out, r_addr_out, r_data_out, r_mar_in, r_mdr_in, r_read;
    logic       r_mem_rd, r_mem_wr;
    logic       r_if_done, r_ld_done, r_st_done;

    logic       w_data_wins;
    logic       w_store;

    // Data class wins unless fetch is also pending and data was granted last.
    assign w_data_wins = (bus.ld_req | bus.st_req) & (~bus.if_req | ~r_last_data);
    assign w_store     = (r_gnt == 2'b11);

    // Sequencer FSM; outputs are registered and decoded for the state being entered.
    always_ff @(posedge clk) begin
        if (clear) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_last_data <= 1'b0;
            r_gnt       <= 2'b00;
            r_busy      <= 1'b0;
            r_pc_out    <= 1'b0;
            r_addr_out  <= 1'b0;
            r_data_out  <= 1'b0;
            r_mar_in    <= 1'b0;
            r_mdr_in    <= 1'b0;
            r_read      <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_if_done   <= 1'b0;
            r_ld_done   <= 1'b0;
            r_st_done   <= 1'b0;
        end else begin
            r_pc_out   <= 1'b0;
            r_addr_out <= 1'b0;
            r_data_out <= 1'b0;
            r_mar_in   <= 1'b0;
            r_mdr_in   <= 1'b0;
            r_read     <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_mem_wr   <= 1'b0;
            r_if_done  <= 1'b0;
            r_ld_done  <= 1'b0;
            r_st_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_data_wins) begin
                        r_gnt       <= bus.st_req ? 2'b11 : 2'b10;
                        r_last_data <= 1'b1;
                        r_busy      <= 1'b1;
                        r_addr_out  <= 1'b1;
                        r_mar_in    <= 1'b1;
                        r_state     <= S_ADDR;
                    end else if (bus.if_req) begin
                        r_gnt       <= 2'b01;
                        r_last_data <= 1'b0;
                        r_busy      <= 1'b1;
                        r_pc_out    <= 1'b1;
                        r_mar_in    <= 1'b1;
                        r_state     <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (w_store) begin
                        r_data_out <= 1'b1;
                        r_state    <= S_SD0;
                    end else begin
                        r_mem_rd <= 1'b1;
                        r_cnt    <= LAT_M1;
                        r_state  <= S_WAIT;
                    end
                end
                S_SD0: begin
                    r_mdr_in <= 1'b1;
                    r_state  <= S_SD1;
                end
                S_SD1: begin
                    r_mem_wr <= 1'b1;
                    r_cnt    <= LAT_M1;
                    r_state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        if (w_store) begin
                            r_st_done <= 1'b1;
                            r_state   <= S_DONE;
                        end else begin
                            r_read  <= 1'b1;
                            r_state <= S_CAP;
                        end
                    end else begin
                        r_cnt    <= r_cnt - 4'd1;
                        r_mem_rd <= ~w_store;
                        r_mem_wr <= w_store;
                    end
                end
                S_CAP: begin
                    r_read   <= 1'b1;
                    r_mdr_in <= 1'b1;
                    r_state  <= S_LAT;
                end
                S_LAT: begin
                    r_if_done <= (r_gnt == 2'b01);
                    r_ld_done <= (r_gnt == 2'b10);
                    r_state   <= S_DONE;
                end
                S_DONE: begin
                    r_gnt   <= 2'b00;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_gnt   <= 2'b00;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.PCout   = r_pc_out;
    assign bus.ADDRout = r_addr_out;
    assign bus.DATAout = r_data_out;
    assign bus.MARin   = r_mar_in;
    assign bus.MDRin   = r_mdr_in;
    assign bus.read    = r_read;
    assign bus.mem_rd  = r_mem_rd;
    assign bus.mem_wr  = r_mem_wr;
    assign bus.gnt     = r_gnt;
    assign bus.busy    = r_busy;
    assign bus.if_done = r_if_done;
    assign bus.ld_done = r_ld_done;
    assign bus.st_done = r_st_done;
endmodule

// File: tb/tb_mem_seq.sv
// Bench for mem_seq: two instances (MEM_LAT 2 and 1) share one stimulus stream
// and are compared every cycle against a transaction-timeline reference model.
module tb_mem_seq;
    logic clk = 1'b0;
    logic clear = 1'b1;
    logic if_req = 1'b0, ld_req = 1'b0, st_req = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mem_seq_if bus2 ();
    mem_seq_if bus1 ();

    assign bus2.if_req = if_req;
    assign bus2.ld_req = ld_req;
    assign bus2.st_req = st_req;
    assign bus1.if_req = if_req;
    assign bus1.ld_req = ld_req;
    assign bus1.st_req = st_req;

    mem_seq #(.MEM_LAT(2)) u_dut2 (.clk(clk), .clear(clear), .bus(bus2.slave));
    mem_seq #(.MEM_LAT(1)) u_dut1 (.clk(clk), .clear(clear), .bus(bus1.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Expected outputs from owner (0 none,1 fetch,2 load,3 store) and the
    // cycle index t within the transaction (ADDR = 1, done = lat+4).
    // Packing: {PCout,ADDRout,DATAout,MARin,MDRin,read,mem_rd,mem_wr,gnt,busy,if_done,ld_done,st_done}
    function automatic logic [13:0] exp_vec(int own, int t, int lat);
        logic pc, ad, da, mi, mdi, rd, mr, mw, fd, ldn, sd;
        {pc, ad, da, mi, mdi, rd, mr, mw, fd, ldn, sd} = '0;
        if (own != 0) begin
            if (t == 1) begin
                mi = 1'b1;
                if (own == 1) pc = 1'b1; else ad = 1'b1;
            end
            if (own == 3) begin
                da  = (t == 2);
                mdi = (t == 3);
                mw  = (t >= 4) && (t <= lat + 3);
            end else begin
                mr  = (t >= 2) && (t <= lat + 1);
                rd  = (t == lat + 2) || (t == lat + 3);
                mdi = (t == lat + 3);
            end
            if (t == lat + 4) begin
                fd  = (own == 1);
                ldn = (own == 2);
                sd  = (own == 3);
            end
        end
        return {pc, ad, da, mi, mdi, rd, mr, mw, 2'(own), (own != 0), fd, ldn, sd};
    endfunction

    int m_own [2];
    int m_t   [2];
    bit m_last_data [2];

    // Reference model advances on each edge; both instances are compared 1 time unit later.
    always @(posedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            int lat;
            lat = (k == 0) ? 2 : 1;
            if (clear) begin
                m_own[k] = 0;
                m_t[k] = 0;
                m_last_data[k] = 1'b0;
            end else if (m_own[k] == 0) begin
                bit data_p;
                data_p = ld_req || st_req;
                if (data_p && (!if_req || !m_last_data[k])) begin
                    m_own[k] = st_req ? 3 : 2;
                    m_last_data[k] = 1'b1;
                    m_t[k] = 1;
                end else if (if_req) begin
                    m_own[k] = 1;
                    m_last_data[k] = 1'b0;
                    m_t[k] = 1;
                end
            end else begin
                m_t[k]++;
                if (m_t[k] > lat + 4) begin
                    m_own[k] = 0;
                    m_t[k] = 0;
                end
            end
        end
        #1;
        chk("lat2_outs", 32'({bus2.PCout, bus2.ADDRout, bus2.DATAout, bus2.MARin, bus2.MDRin,
                              bus2.read, bus2.mem_rd, bus2.mem_wr, bus2.gnt, bus2.busy,
                              bus2.if_done, bus2.ld_done, bus2.st_done}),
            32'(exp_vec(m_own[0], m_t[0], 2)));
        chk("lat1_outs", 32'({bus1.PCout, bus1.ADDRout, bus1.DATAout, bus1.MARin, bus1.MDRin,
                              bus1.read, bus1.mem_rd, bus1.mem_wr, bus1.gnt, bus1.busy,
                              bus1.if_done, bus1.ld_done, bus1.st_done}),
            32'(exp_vec(m_own[1], m_t[1], 1)));
    end

    function automatic logic done_of(int which, int sel);
        if (which == 2) return (sel == 0) ? bus2.if_done : (sel == 1) ? bus2.ld_done : bus2.st_done;
        return (sel == 0) ? bus1.if_done : (sel == 1) ? bus1.ld_done : bus1.st_done;
    endfunction

    // Cycles from c0 until the selected done pulse; -1 if the budget expires.
    task automatic wait_done(input int which, input int sel, input int c0, output int got);
        got = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_of(which, sel)) begin
                got = cyc - c0;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear = 1'b1;
        if_req = 1'b0; ld_req = 1'b0; st_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        int c0, got, d_if, d_ld, d_st;
        do_reset();
        chk("rst_gnt", 32'(bus2.gnt), 32'd0);
        chk("rst_busy", 32'(bus2.busy), 32'd0);

        // Fetch, MEM_LAT 2
        if_req = 1'b1; c0 = cyc;
        wait_done(2, 0, c0, got);
        if_req = 1'b0;
        chk("fetch_done_cyc", 32'(got), 32'd6);

        // Store, MEM_LAT 2
        do_reset();
        st_req = 1'b1; c0 = cyc;
        wait_done(2, 2, c0, got);
        st_req = 1'b0;
        chk("store_done_cyc", 32'(got), 32'd6);

        // Three-way contention from reset: store, fetch, load
        do_reset();
        if_req = 1'b1; ld_req = 1'b1; st_req = 1'b1; c0 = cyc;
        d_if = -1; d_ld = -1; d_st = -1;
        for (int i = 0; i < 40 && (d_if < 0 || d_ld < 0 || d_st < 0); i++) begin
            @(negedge clk);
            if (bus2.if_done) begin d_if = cyc - c0; if_req = 1'b0; end
            if (bus2.ld_done) begin d_ld = cyc - c0; ld_req = 1'b0; end
            if (bus2.st_done) begin d_st = cyc - c0; st_req = 1'b0; end
        end
        chk("rr_store_done", 32'(d_st), 32'd6);
        chk("rr_fetch_done", 32'(d_if), 32'd13);
        chk("rr_load_done", 32'(d_ld), 32'd20);
        if_req = 1'b0; ld_req = 1'b0; st_req = 1'b0;

        // Clear during a load at cycle 3, then the load reruns
        do_reset();
        ld_req = 1'b1; c0 = cyc;
        while (cyc < c0 + 3) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        chk("clr_gnt", 32'(bus2.gnt), 32'd0);
        chk("clr_busy", 32'(bus2.busy), 32'd0);
        chk("clr_no_done", 32'(bus2.ld_done), 32'd0);
        clear = 1'b0; c0 = cyc;
        wait_done(2, 1, c0, got);
        ld_req = 1'b0;
        chk("rerun_ld_done", 32'(got), 32'd6);

        // Load on both instances: MEM_LAT 1 done at 5, MEM_LAT 2 at 6
        do_reset();
        ld_req = 1'b1; c0 = cyc;
        wait_done(1, 1, c0, got);
        ld_req = 1'b0;
        chk("lat1_ld_done", 32'(got), 32'd5);
        wait_done(2, 1, c0, got);
        chk("lat2_ld_done", 32'(got), 32'd6);

        // Load dropped at cycle 2 still completes
        do_reset();
        ld_req = 1'b1; c0 = cyc;
        while (cyc < c0 + 2) @(negedge clk);
        ld_req = 1'b0;
        wait_done(2, 1, c0, got);
        chk("drop_ld_done", 32'(got), 32'd6);

        // Randomized request traffic with occasional clear
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            clear = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 5) == 0) if_req = ~if_req;
            if ($urandom_range(0, 5) == 0) ld_req = ~ld_req;
            if ($urandom_range(0, 7) == 0) st_req = ~st_req;
            if (bus2.if_done && $urandom_range(0, 3) != 0) if_req = 1'b0;
            if (bus2.ld_done && $urandom_range(0, 3) != 0) ld_req = 1'b0;
            if (bus2.st_done && $urandom_range(0, 3) != 0) st_req = 1'b0;
        end
        @(negedge clk);
        clear = 1'b0;
        if_req = 1'b0; ld_req = 1'b0; st_req = 1'b0;
        repeat (12) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
